// File: rtl/snake_pkg.sv
// Shared score-display definitions: segment codes, converter states and decimal range helper.
package snake_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_LOAD,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  // Active-low {gfedcba}; non-decimal nibbles cannot occur and show blank.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Largest value representable in the given number of decimal digits.
  function automatic int max_val(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Iterative double-dabble binary-to-BCD converter: one LOAD cycle, OPND_W SHIFT cycles, one DONE cycle.
module bcd_dabble_seq
  import snake_pkg::*;
#(
  parameter int OPND_W = 7,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OPND_W-1:0]   operand,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(OPND_W + 1);

  conv_state_t        state;
  logic [OPND_W-1:0]  opnd;
  logic [CNT_W-1:0]   cnt;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // A new start is accepted in DONE as well, so back-to-back requests lose no cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CONV_IDLE;
      opnd  <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        CONV_IDLE, CONV_DONE: begin
          if (start) begin
            state <= CONV_LOAD;
            opnd  <= operand;
            bcd   <= '0;
            cnt   <= CNT_W'(OPND_W);
          end else begin
            state <= CONV_IDLE;
          end
        end
        CONV_LOAD: state <= CONV_SHIFT;
        CONV_SHIFT: begin
          bcd  <= {adj[4*DIGITS-2:0], opnd[OPND_W-1]};
          opnd <= opnd << 1;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= CONV_DONE;
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end

  assign busy = (state != CONV_IDLE);
  assign done = (state == CONV_DONE);

endmodule

// File: rtl/score_hex_display.sv
// Score / high-score seven-segment driver with saturation, record tracking and blink.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero digit.
module score_hex_display
  import snake_pkg::*;
#(
  parameter int SCORE_W   = 7,
  parameter int DIGITS    = 2,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                 clk_25MHz,
  input  logic                 reset_n,
  input  logic [SCORE_W-1:0]   score,
  input  logic                 game_over,
  input  logic                 clear_high,
  output logic [7*DIGITS-1:0]  hex_score,
  output logic [7*DIGITS-1:0]  hex_high,
  output logic                 new_record,
  output logic                 busy
);

  localparam int MAX_VAL = max_val(DIGITS);
  localparam int SEG_W   = 7 * DIGITS;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);

  function automatic logic [SEG_W-1:0] encode_digits(input logic [BCD_W-1:0] bcd_val);
    logic [SEG_W-1:0] segs;
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    segs = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      segs[7*d +: 7] = seg7_encode(bcd_val[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (lead && d != 0 && bcd_val[4*d +: 4] == 4'd0) segs[7*d +: 7] = SEG_BLANK;
      else lead = 1'b0;
`endif
    end
    return segs;
  endfunction

  function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] v);
    if (int'(v) > MAX_VAL) return SCORE_W'(MAX_VAL);
    return v;
  endfunction

  localparam logic [SEG_W-1:0] SEG_ZERO = encode_digits('0);

  logic [SCORE_W-1:0] high_score;
  logic [SCORE_W-1:0] score_last;
  logic [SCORE_W-1:0] operand;
  logic [BCD_W-1:0]   bcd;
  logic [SEG_W-1:0]   hex_score_r;
  logic [SEG_W-1:0]   hex_high_r;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic               high_req;
  logic               tgt_high;
  logic               go_q;
  logic               go_rise;
  logic               conv_busy;
  logic               conv_done;
  logic               idle_ok;
  logic               score_pend;
  logic               start;

  // The score request stays pending by construction: score_last only moves when it is served.
  assign idle_ok    = !conv_busy || conv_done;
  assign score_pend = idle_ok && (score != score_last);
  assign start      = idle_ok && (score_pend || high_req);
  assign operand    = saturate(score_pend ? score : high_score);
  assign go_rise    = game_over && !go_q;

  bcd_dabble_seq #(
    .OPND_W (SCORE_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk_25MHz),
    .rst_n   (reset_n),
    .start   (start),
    .operand (operand),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (bcd)
  );

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      high_score  <= '0;
      score_last  <= '0;
      new_record  <= 1'b0;
      high_req    <= 1'b0;
      tgt_high    <= 1'b0;
      go_q        <= 1'b0;
      hex_score_r <= SEG_ZERO;
      hex_high_r  <= SEG_ZERO;
      blink_cnt   <= BLINK_W'(BLINK_DIV - 1);
      blink_on    <= 1'b1;
    end else begin
      go_q <= game_over;

      if (start) begin
        tgt_high <= !score_pend;
        if (score_pend) score_last <= score;
      end

      if (clear_high) begin
        high_score <= '0;
        new_record <= 1'b0;
      end else if (go_rise) begin
        if (score > high_score) begin
          high_score <= score;
          new_record <= 1'b1;
        end else begin
          new_record <= 1'b0;
        end
      end

      // A fresh high-score update outranks serving the stale one in the same cycle.
      high_req <= (high_req && !(start && !score_pend)) || clear_high ||
                  (go_rise && (score > high_score));

      if (conv_done) begin
        if (tgt_high) hex_high_r  <= encode_digits(bcd);
        else          hex_score_r <= encode_digits(bcd);
      end

      if (blink_cnt == '0) begin
        blink_cnt <= BLINK_W'(BLINK_DIV - 1);
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt - BLINK_W'(1);
      end
    end
  end

  assign hex_score = hex_score_r;
  assign hex_high  = (new_record && !blink_on) ? {DIGITS{SEG_BLANK}} : hex_high_r;
  assign busy      = conv_busy;

endmodule

// File: tb/tb_score_hex_display.sv
// Directed self-checking bench for score_hex_display (DIGITS=2, SCORE_W=7, BLINK_DIV=4).
module tb_score_hex_display;

  localparam int SCORE_W   = 7;
  localparam int DIGITS    = 2;
  localparam int BLINK_DIV = 4;

  localparam logic [13:0] SEG_57 = {7'h12, 7'h78};
  localparam logic [13:0] SEG_99 = {7'h10, 7'h10};
  localparam logic [13:0] SEG_42 = {7'h19, 7'h24};
  localparam logic [13:0] SEG_30 = {7'h30, 7'h40};
  localparam logic [13:0] SEG_11 = {7'h79, 7'h79};
  localparam logic [13:0] SEG_50 = {7'h12, 7'h40};
  localparam logic [13:0] SEG_OFF = {7'h7F, 7'h7F};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [13:0] SEG_0 = {7'h7F, 7'h40};
  localparam logic [13:0] SEG_7 = {7'h7F, 7'h78};
`else
  localparam logic [13:0] SEG_0 = {7'h40, 7'h40};
  localparam logic [13:0] SEG_7 = {7'h40, 7'h78};
`endif

  logic                clk_25MHz = 1'b0;
  logic                reset_n;
  logic [SCORE_W-1:0]  score;
  logic                game_over;
  logic                clear_high;
  logic [7*DIGITS-1:0] hex_score;
  logic [7*DIGITS-1:0] hex_high;
  logic                new_record;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  score_hex_display #(
    .SCORE_W   (SCORE_W),
    .DIGITS    (DIGITS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk_25MHz  (clk_25MHz),
    .reset_n    (reset_n),
    .score      (score),
    .game_over  (game_over),
    .clear_high (clear_high),
    .hex_score  (hex_score),
    .hex_high   (hex_high),
    .new_record (new_record),
    .busy       (busy)
  );

  always #5 clk_25MHz = ~clk_25MHz;

  // Edges since reset release; the blink phase is off during odd multiples of BLINK_DIV.
  always @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    score      = 7'd0;
    game_over  = 1'b0;
    clear_high = 1'b0;
    #12;
    check("rst_hex_score", 32'(hex_score), 32'(SEG_0));
    check("rst_hex_high", 32'(hex_high), 32'(SEG_0));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_new_record", 32'(new_record), 32'd0);
    @(negedge clk_25MHz) reset_n = 1'b1;
    repeat (3) @(posedge clk_25MHz);
    #1 check("idle_busy", 32'(busy), 32'd0);

    // 0 -> 57: busy from the sampling edge, result 9 edges later
    @(negedge clk_25MHz) score = 7'd57;
    @(posedge clk_25MHz);
    #1 check("conv_busy_first", 32'(busy), 32'd1);
    repeat (8) @(posedge clk_25MHz);
    #1 check("conv_busy_last", 32'(busy), 32'd1);
    check("conv_hold_old", 32'(hex_score), 32'(SEG_0));
    @(posedge clk_25MHz);
    #1 check("conv_57", 32'(hex_score), 32'(SEG_57));
    check("conv_busy_end", 32'(busy), 32'd0);

    @(negedge clk_25MHz) score = 7'd120;
    repeat (10) @(posedge clk_25MHz);
    #1 check("sat_120", 32'(hex_score), 32'(SEG_99));

    @(negedge clk_25MHz) score = 7'd7;
    repeat (10) @(posedge clk_25MHz);
    #1 check("digit_7", 32'(hex_score), 32'(SEG_7));

    // new record at 42, then blink with period 2*BLINK_DIV
    @(negedge clk_25MHz);
    score     = 7'd42;
    game_over = 1'b1;
    repeat (20) @(posedge clk_25MHz);
    #1 check("rec_set", 32'(new_record), 32'd1);
    check("rec_score", 32'(hex_score), 32'(SEG_42));
    for (int i = 0; i < 8; i++) begin
      check("rec_blink", 32'(hex_high), ((cyc / BLINK_DIV) % 2 == 0) ? 32'(SEG_42) : 32'(SEG_OFF));
      @(posedge clk_25MHz);
      #1;
    end

    // second game over at 30: not a record, steady display of 42
    @(negedge clk_25MHz) game_over = 1'b0;
    @(negedge clk_25MHz);
    score     = 7'd30;
    game_over = 1'b1;
    repeat (12) @(posedge clk_25MHz);
    #1 check("norec_flag", 32'(new_record), 32'd0);
    check("norec_score", 32'(hex_score), 32'(SEG_30));
    for (int i = 0; i < 5; i++) begin
      check("norec_steady", 32'(hex_high), 32'(SEG_42));
      @(posedge clk_25MHz);
      #1;
    end

    // 10 then 11 one cycle later: the second value must not be lost
    @(negedge clk_25MHz) score = 7'd10;
    @(posedge clk_25MHz);
    @(negedge clk_25MHz) score = 7'd11;
    repeat (18) @(posedge clk_25MHz);
    #1 check("midconv_11", 32'(hex_score), 32'(SEG_11));
    check("midconv_busy", 32'(busy), 32'd0);

    // clear_high coincident with a game_over edge at 50
    @(negedge clk_25MHz) game_over = 1'b0;
    @(negedge clk_25MHz);
    score      = 7'd50;
    game_over  = 1'b1;
    clear_high = 1'b1;
    @(negedge clk_25MHz) clear_high = 1'b0;
    repeat (20) @(posedge clk_25MHz);
    #1 check("clr_flag", 32'(new_record), 32'd0);
    check("clr_high", 32'(hex_high), 32'(SEG_0));
    check("clr_score", 32'(hex_score), 32'(SEG_50));

    // reset during SHIFT, then reconversion of the held score
    @(negedge clk_25MHz);
    game_over = 1'b0;
    score     = 7'd99;
    repeat (4) @(posedge clk_25MHz);
    #2 check("shift_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1 check("arst_busy", 32'(busy), 32'd0);
    check("arst_hex_score", 32'(hex_score), 32'(SEG_0));
    check("arst_hex_high", 32'(hex_high), 32'(SEG_0));
    check("arst_new_record", 32'(new_record), 32'd0);
    @(negedge clk_25MHz) reset_n = 1'b1;
    repeat (10) @(posedge clk_25MHz);
    #1 check("reconv_99", 32'(hex_score), 32'(SEG_99));
    check("reconv_high", 32'(hex_high), 32'(SEG_0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
